ex_mul_unit: RTL and testbench
==============================

EX_MUL_UNIT -- requirements
Module: ex_mul_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width; bit 0 is the MSB on every vector (big-endian [0:N-1] ordering).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; forces all state to reset values immediately while low.
REQ-004 start  input  1  ID/EX output: instruction in EX is valid and has its mul bit set.
REQ-005 signed_op  input  1  1 = signed two's-complement multiply, 0 = unsigned.
REQ-006 opA  input  WIDTH  multiplicand, taken from the ID/EX opA field.
REQ-007 opB  input  WIDTH  multiplier, taken from the ID/EX opB field.
REQ-008 flush  input  1  squash the instruction in EX (branch/jump redirect).
REQ-009 stall  output  1  freeze PC, IF/ID and ID/EX while the multiply is in progress.
REQ-010 result_valid  output  1  one-cycle pulse; product is available.
REQ-011 result_hi  output  WIDTH  upper WIDTH bits of the 2*WIDTH-bit product.
REQ-012 result_lo  output  WIDTH  lower WIDTH bits of the 2*WIDTH-bit product.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; exactly one state active.
REQ-014 IDLE, start=1, flush=0: latch |opA|, |opB| (magnitudes if signed_op, raw values otherwise), latch sign = signed_op & (opA[0] ^ opB[0]), clear the accumulator, clear the iteration counter, then go to BUSY.
REQ-015 BUSY: one shift-add iteration per cycle (accumulator += multiplicand when the current multiplier bit is 1, then shift), then counter increments.
REQ-016 BUSY to DONE after exactly WIDTH iterations; the counter is log2(WIDTH)+1 bits wide and has no wrap-around hazard.
REQ-017 On entering DONE: result_hi:result_lo = accumulator, two's-complement negated across all 2*WIDTH bits when sign=1.
REQ-018 DONE lasts exactly one cycle with result_valid=1, then the FSM returns to IDLE; start is ignored in DONE, because the same instruction is still present in ID/EX.
REQ-019 stall = ~flush & ((IDLE & start) | BUSY); stall is combinational so the mul instruction is held from its first EX cycle; stall=0 in DONE.
REQ-020 Latency: start accepted in cycle 0; result_valid high in cycle WIDTH+1; stall high in cycles 0..WIDTH inclusive.
REQ-021 Back-to-back multiplies: a start seen in the IDLE cycle immediately after DONE begins a new operation with no extra bubble.
REQ-022 flush=1 in any state: next state is IDLE; result_valid=0 in the following cycle; result_hi/result_lo are not updated; the operation in flight is discarded.
REQ-023 flush and start both high in IDLE: flush wins; no operation starts and stall=0.
REQ-024 result_hi/result_lo hold their last value until the next DONE.
REQ-025 Signed corner case: the magnitude of the most negative value (e.g. 0x80000000) is treated as the unsigned value 2^(WIDTH-1), and the result is correct.

Reset
REQ-026 reset low: state=IDLE, counter=0, accumulator=0, sign=0, result_hi=0, result_lo=0, result_valid=0.
REQ-027 stall=0 while reset is low, regardless of start.
REQ-028 reset asserted mid-BUSY aborts the operation; after reset is released, no result_valid is produced for the aborted operation.
REQ-029 Operation resumes on the first rising clk edge after reset deasserts.

Verification
REQ-030 Unsigned 3 x 5, start at cycle 0 -> stall high cycles 0..32; result_valid in cycle 33 only; hi=0x00000000, lo=0x0000000F.
REQ-031 opA=0xFFFFFFFE, opB=3: signed -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; unsigned -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-032 Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-033 flush pulsed in cycle 10 of an operation -> stall=0 in cycle 10; FSM in IDLE in cycle 11; no result_valid; result outputs keep their previous values.
REQ-034 reset pulsed low mid-BUSY -> all outputs 0 immediately; after release with start=0, stall stays 0 and no result_valid appears.
REQ-035 Two consecutive muls (7x6, then 2x-1 signed) -> result_valid in cycles 33 and 67; results 42, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; stall low only in cycle 33.

Source files
------------

// File: rtl/ex_mul_unit.sv
// ex_mul_unit: multi-cycle shift-add multiplier for EX; stalls the pipeline until the 2*WIDTH-bit product is ready
module ex_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [0:WIDTH-1] opA,
  input  logic [0:WIDTH-1] opB,
  input  logic             flush,
  output logic             stall,
  output logic             result_valid,
  output logic [0:WIDTH-1] result_hi,
  output logic [0:WIDTH-1] result_lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [0:1] {IDLE, BUSY, DONE} stateE;
  stateE state, nextState;
  logic [0:WIDTH-1] mcand, mplier, magA, magB;
  logic [0:2*WIDTH-1] acc, accNext;
  logic [0:CW-1] cnt;
  logic sign, accept, last;
  always_comb begin
    magA = (signed_op && opA[0]) ? -opA : opA;
    magB = (signed_op && opB[0]) ? -opB : opB;
    accept = state == IDLE && start && !flush;
    last = state == BUSY && cnt == CW'(WIDTH - 1);
    accNext = (acc << 1) + (mplier[0] ? {{WIDTH{1'b0}}, mcand} : '0);
    nextState = flush ? IDLE : accept ? BUSY : last ? DONE : state == BUSY ? BUSY : IDLE;
    stall = reset && !flush && ((state == IDLE && start) || state == BUSY);
    result_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      sign <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        mcand <= magA;
        mplier <= magB;
        sign <= signed_op && (opA[0] ^ opB[0]);
        acc <= '0;
        cnt <= '0;
      end else if (state == BUSY) begin
        acc <= accNext;
        mplier <= mplier << 1;
        cnt <= cnt + CW'(1);
      end
      if (last && !flush) {result_hi, result_lo} <= sign ? -accNext : accNext;
    end
  end
endmodule

// File: tb/tb_ex_mul_unit.sv
// tb_ex_mul_unit: randomized and directed self-checking bench for ex_mul_unit against a cycle-level behavioural model
module tb_ex_mul_unit;
  logic clk = 1'b0;
  logic reset, start, signed_op, flush, stall, result_valid;
  logic [0:31] opA, opB, result_hi, result_lo;
  int checks = 0;
  int failures = 0;
  int mLeft = 0;
  logic mDone = 1'b0;
  logic [63:0] mRes = '0;
  logic [63:0] mPend = '0;
  logic expStall;
  logic held;
  int cntV, cntS;
  ex_mul_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_op(signed_op),
    .opA(opA),
    .opB(opB),
    .flush(flush),
    .stall(stall),
    .result_valid(result_valid),
    .result_hi(result_hi),
    .result_lo(result_lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    return s ? 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})) : {32'b0, a} * {32'b0, b};
  endfunction
  function automatic logic [31:0] rnd();
    int k;
    k = $urandom_range(0, 7);
    if (k == 0) return 32'h0;
    if (k == 1) return 32'h80000000;
    if (k == 2) return 32'hFFFFFFFF;
    if (k == 3) return 32'h7FFFFFFF;
    if (k == 4) return 32'h1;
    return $urandom();
  endfunction
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mLeft = 0;
        mDone = 1'b0;
        mRes = '0;
      end
      expStall = reset && !flush && ((mLeft == 0 && !mDone && start) || mLeft > 0);
      chk("cyc stall", 64'(stall), 64'(expStall));
      chk("cyc valid", 64'(result_valid), 64'(mDone));
      chk("cyc hi", 64'(result_hi), 64'(mRes[63:32]));
      chk("cyc lo", 64'(result_lo), 64'(mRes[31:0]));
      if (reset) begin
        if (flush) begin
          mLeft = 0;
          mDone = 1'b0;
        end else if (mDone) mDone = 1'b0;
        else if (mLeft > 0) begin
          mLeft--;
          if (mLeft == 0) begin
            mDone = 1'b1;
            mRes = mPend;
          end
        end else if (start) begin
          mLeft = 32;
          mPend = prod(signed_op, opA, opB);
        end
      end
    end
  end
  task automatic mulOp(input string nm, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int n;
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_op = s;
    opA = a;
    opB = b;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (result_valid) break;
    end
    chk({nm, " latency"}, 64'(n), 64'd33);
    chk({nm, " hi"}, 64'(result_hi), 64'(exp[63:32]));
    chk({nm, " lo"}, 64'(result_lo), 64'(exp[31:0]));
  endtask
  initial begin
    reset = 1'b0;
    start = 1'b1;
    flush = 1'b0;
    signed_op = 1'b1;
    opA = 32'h80000000;
    opB = 32'h5;
    repeat (2) @(negedge clk);
    chk("reset stall", 64'(stall), 64'd0);
    chk("reset valid", 64'(result_valid), 64'd0);
    chk("reset hi", 64'(result_hi), 64'd0);
    chk("reset lo", 64'(result_lo), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    mulOp("u3x5", 1'b0, 32'h3, 32'h5, 64'h0000000000_00000F);
    mulOp("sFEx3", 1'b1, 32'hFFFFFFFE, 32'h3, 64'hFFFFFFFF_FFFFFFFA);
    mulOp("uFEx3", 1'b0, 32'hFFFFFFFE, 32'h3, 64'h00000002_FFFFFFFA);
    mulOp("uFFxFF", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    mulOp("s80x80", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    mulOp("u7x6", 1'b0, 32'h7, 32'h6, 64'h00000000_0000002A);
    mulOp("s2xm1", 1'b1, 32'h2, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE);
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_op = 1'b0;
    opA = 32'hDEADBEEF;
    opB = 32'h1234;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    cntV = 0;
    cntS = 0;
    repeat (40) begin
      @(negedge clk);
      cntV += int'(result_valid);
      cntS += int'(stall);
    end
    chk("flush no valid", 64'(cntV), 64'd0);
    chk("flush no stall", 64'(cntS), 64'd0);
    chk("flush hi kept", 64'(result_hi), 64'hFFFFFFFF);
    chk("flush lo kept", 64'(result_lo), 64'hFFFFFFFE);
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_op = 1'b1;
    opA = 32'h12345678;
    opB = 32'hFFFF0001;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("areset stall", 64'(stall), 64'd0);
    chk("areset valid", 64'(result_valid), 64'd0);
    chk("areset hi", 64'(result_hi), 64'd0);
    chk("areset lo", 64'(result_lo), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cntV = 0;
    cntS = 0;
    repeat (40) begin
      @(negedge clk);
      cntV += int'(result_valid);
      cntS += int'(stall);
    end
    chk("post reset no valid", 64'(cntV), 64'd0);
    chk("post reset no stall", 64'(cntS), 64'd0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      held = stall;
      @(posedge clk);
      #1;
      if (!held) begin
        start = $urandom_range(0, 3) != 0;
        signed_op = 1'($urandom_range(0, 1));
        opA = rnd();
        opB = rnd();
      end
      flush = $urandom_range(0, 59) == 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
